// File: rtl/picomem_mux_1_n.sv
// picomem_mux_1_n: registered 1-to-N PicoRV32 native-bus mux with base/mask
// decode, unmapped-address error responder and per-transaction slave timeout.
// Optional first-error log is built when PICOMEM_MUX_ERRLOG_EN is defined.
module picomem_mux_1_n #(
   parameter int unsigned NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES*32-1:0] ADDR_BASES =
      {32'hC300_0000, 32'hC200_0000, 32'hC100_0000, 32'hC000_0000},
   parameter logic [NUM_SLAVES*32-1:0] ADDR_MASKS = {4{32'hFF00_0000}},
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA = 32'hBADC0DE5
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     picom_valid,
   output logic                     picom_ready,
   input  logic [31:0]              picom_addr,
   input  logic [31:0]              picom_wdata,
   input  logic [3:0]               picom_wstrb,
   output logic [31:0]              picom_rdata,
   output logic [NUM_SLAVES-1:0]    picos_valid,
   input  logic [NUM_SLAVES-1:0]    picos_ready,
   output logic [31:0]              picos_addr,
   output logic [31:0]              picos_wdata,
   output logic [3:0]               picos_wstrb,
   input  logic [NUM_SLAVES*32-1:0] picos_rdata,
`ifdef PICOMEM_MUX_ERRLOG_EN
   input  logic                     err_clr,
   output logic                     err_valid,
   output logic [31:0]              err_addr,
   output logic                     err_timeout,
`endif
   output logic                     err_pulse
);

   localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned CNT_W = 16;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_SLAVES-1:0] valid_d;
   logic [31:0]           addr_d, wdata_d, rdata_d;
   logic [3:0]            wstrb_d;
   logic                  ready_d, err_d;

   logic                  hit_c;
   logic [SEL_W-1:0]      sel_c;
   logic                  sel_ready_c;
   logic [31:0]           sel_rdata_c;
   logic                  timeout_hit_c;
   logic                  err_ev_c;
   logic                  err_to_c;

   // Address decode; scanning downwards lets the lowest matching index win
   always_comb begin
      hit_c = 1'b0;
      sel_c = '0;
      for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
         if ((picom_addr & ADDR_MASKS[i*32 +: 32]) ==
             (ADDR_BASES[i*32 +: 32] & ADDR_MASKS[i*32 +: 32])) begin
            hit_c = 1'b1;
            sel_c = SEL_W'(i);
         end
      end
   end

   // Pick ready/rdata of the latched slave; other slaves' ready is ignored
   always_comb begin
      sel_ready_c = 1'b0;
      sel_rdata_c = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (sel_q == SEL_W'(i)) begin
            sel_ready_c = picos_ready[i];
            sel_rdata_c = picos_rdata[i*32 +: 32];
         end
      end
   end

   // Watchdog limit reached on this ACTIVE cycle (disabled when limit is 0)
   assign timeout_hit_c = (TIMEOUT_CYCLES != 0) &&
                          (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      valid_d  = picos_valid;
      addr_d   = picos_addr;
      wdata_d  = picos_wdata;
      wstrb_d  = picos_wstrb;
      rdata_d  = picom_rdata;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      err_ev_c = 1'b0;
      err_to_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (picom_valid) begin
               if (hit_c) begin
                  addr_d  = picom_addr;
                  wdata_d = picom_wdata;
                  wstrb_d = picom_wstrb;
                  sel_d   = sel_c;
                  valid_d = NUM_SLAVES'(1) << sel_c;
                  cnt_d   = '0;
                  state_d = ST_ACTIVE;
               end else begin
                  rdata_d  = ERR_RDATA;
                  ready_d  = 1'b1;
                  err_d    = 1'b1;
                  err_ev_c = 1'b1;
                  state_d  = ST_RESP;
               end
            end
         end
         ST_ACTIVE: begin
            if (sel_ready_c) begin
               rdata_d = sel_rdata_c;
               ready_d = 1'b1;
               valid_d = '0;
               state_d = ST_RESP;
            end else if (timeout_hit_c) begin
               rdata_d  = ERR_RDATA;
               ready_d  = 1'b1;
               err_d    = 1'b1;
               err_ev_c = 1'b1;
               err_to_c = 1'b1;
               valid_d  = '0;
               state_d  = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            valid_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         cnt_q       <= '0;
         picos_valid <= '0;
         picos_addr  <= '0;
         picos_wdata <= '0;
         picos_wstrb <= '0;
         picom_rdata <= '0;
         picom_ready <= 1'b0;
         err_pulse   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         picos_valid <= valid_d;
         picos_addr  <= addr_d;
         picos_wdata <= wdata_d;
         picos_wstrb <= wstrb_d;
         picom_rdata <= rdata_d;
         picom_ready <= ready_d;
         err_pulse   <= err_d;
      end
   end

`ifdef PICOMEM_MUX_ERRLOG_EN
   // First-error log: sticky until err_clr, which beats a same-cycle capture
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_valid   <= 1'b0;
         err_addr    <= '0;
         err_timeout <= 1'b0;
      end else if (err_clr) begin
         err_valid   <= 1'b0;
         err_addr    <= '0;
         err_timeout <= 1'b0;
      end else if (err_ev_c && !err_valid) begin
         err_valid   <= 1'b1;
         err_addr    <= err_to_c ? picos_addr : picom_addr;
         err_timeout <= err_to_c;
      end
   end
`endif

endmodule

// File: tb/tb_picomem_mux_1_n.sv
// tb_picomem_mux_1_n: scoreboard bench for picomem_mux_1_n with TIMEOUT_CYCLES=8.
// Define PICOMEM_MUX_ERRLOG_EN for both files to also exercise the error log.
module tb_picomem_mux_1_n;

   localparam int NS    = 4;
   localparam int NEVER = 1000;

   logic              clk = 1'b0;
   logic              resetn;
   logic              picom_valid;
   logic              picom_ready;
   logic [31:0]       picom_addr;
   logic [31:0]       picom_wdata;
   logic [3:0]        picom_wstrb;
   logic [31:0]       picom_rdata;
   logic [NS-1:0]     picos_valid;
   logic [NS-1:0]     picos_ready;
   logic [31:0]       picos_addr;
   logic [31:0]       picos_wdata;
   logic [3:0]        picos_wstrb;
   logic [NS*32-1:0]  picos_rdata;
   logic              err_pulse;
`ifdef PICOMEM_MUX_ERRLOG_EN
   logic              err_clr;
   logic              err_valid;
   logic [31:0]       err_addr;
   logic              err_timeout;
`endif

   picomem_mux_1_n #(
      .NUM_SLAVES(NS),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .picom_valid(picom_valid),
      .picom_ready(picom_ready),
      .picom_addr(picom_addr),
      .picom_wdata(picom_wdata),
      .picom_wstrb(picom_wstrb),
      .picom_rdata(picom_rdata),
      .picos_valid(picos_valid),
      .picos_ready(picos_ready),
      .picos_addr(picos_addr),
      .picos_wdata(picos_wdata),
      .picos_wstrb(picos_wstrb),
      .picos_rdata(picos_rdata),
`ifdef PICOMEM_MUX_ERRLOG_EN
      .err_clr(err_clr),
      .err_valid(err_valid),
      .err_addr(err_addr),
      .err_timeout(err_timeout),
`endif
      .err_pulse(err_pulse)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Slave models: slave i raises ready when it has seen valid for lat[i] cycles
   int          lat  [NS];
   logic [31:0] srd  [NS];
   int          scnt [NS];

   always @(negedge clk) begin
      for (int i = 0; i < NS; i++) begin
         picos_rdata[i*32 +: 32] = srd[i];
         if (picos_valid[i] === 1'b1) begin
            picos_ready[i] = (scnt[i] == lat[i]);
            scnt[i]++;
         end else begin
            picos_ready[i] = 1'b0;
            scnt[i] = 0;
         end
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          start;
      int          lat;
   } exp_t;

   exp_t        q[$];
   logic [NS-1:0] exp_sv;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_wstrb;

   // Monitor: pops the scoreboard on every master completion
   always @(negedge clk) begin
      exp_t e;
      if (resetn === 1'b1) begin
         if (picom_ready === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_ready", 32'(q.size()), 32'd1);
            end else begin
               e = q.pop_front();
               chk("rdata", picom_rdata, e.rdata);
               chk("err_pulse", 32'(err_pulse), 32'(e.err));
               chk("latency", 32'(cyc - e.start), 32'(e.lat));
            end
         end else if (err_pulse !== 1'b0) begin
            chk("err_without_ready", 32'(err_pulse), 32'd0);
         end
         if (picos_valid !== '0) begin
            chk("picos_valid", 32'(picos_valid), 32'(exp_sv));
            chk("picos_addr", picos_addr, exp_addr);
            chk("picos_wdata", picos_wdata, exp_wdata);
            chk("picos_wstrb", 32'(picos_wstrb), 32'(exp_wstrb));
         end
      end
   end

   // Issue one transaction at an IDLE negedge and wait (bounded) for completion
   task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [NS-1:0] sv,
                         input logic [31:0] erd, input logic eerr,
                         input int elat, input int evc);
      exp_t e;
      int   n, vc;
      bit   done;
      @(negedge clk);
      exp_sv      = sv;
      exp_addr    = addr;
      exp_wdata   = wdata;
      exp_wstrb   = wstrb;
      picom_addr  = addr;
      picom_wdata = wdata;
      picom_wstrb = wstrb;
      picom_valid = 1'b1;
      e.rdata = erd; e.err = eerr; e.start = cyc; e.lat = elat;
      q.push_back(e);
      n = 0; vc = 0; done = 1'b0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
         if (picos_valid !== '0) vc++;
         if (picom_ready === 1'b1) done = 1'b1;
      end
      picom_valid = 1'b0;
      if (!done) chk("txn_timeout", 32'd0, 32'd1);
      chk("valid_cycles", 32'(vc), 32'(evc));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      resetn      = 1'b0;
      picom_valid = 1'b0;
      picom_addr  = '0;
      picom_wdata = '0;
      picom_wstrb = '0;
      exp_sv = '0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
`ifdef PICOMEM_MUX_ERRLOG_EN
      err_clr = 1'b0;
`endif
      for (int i = 0; i < NS; i++) begin
         lat[i] = NEVER;
         srd[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_picom_ready", 32'(picom_ready), 32'd0);
      chk("rst_picom_rdata", picom_rdata, 32'd0);
      chk("rst_picos_valid", 32'(picos_valid), 32'd0);
      chk("rst_picos_addr", picos_addr, 32'd0);
      chk("rst_picos_wdata", picos_wdata, 32'd0);
      chk("rst_picos_wstrb", 32'(picos_wstrb), 32'd0);
      chk("rst_err_pulse", 32'(err_pulse), 32'd0);
`ifdef PICOMEM_MUX_ERRLOG_EN
      chk("rst_err_valid", 32'(err_valid), 32'd0);
`endif
      resetn = 1'b1;

      // Zero-wait read from slave 2
      lat[2] = 0; srd[2] = 32'h1234_5678;
      do_txn(32'hC200_0010, 32'h0, 4'b0000, 4'b0100, 32'h1234_5678, 1'b0, 2, 1);
      @(negedge clk);
      chk("rdata_hold", picom_rdata, 32'h1234_5678);
      chk("ready_is_pulse", 32'(picom_ready), 32'd0);

      // Write to slave 1 that answers after 5 wait cycles
      lat[1] = 5; srd[1] = 32'hCAFE_0001;
      do_txn(32'hC100_0004, 32'hA5A5_0001, 4'b0011, 4'b0010, 32'hCAFE_0001, 1'b0, 7, 6);

      // Unmapped write: immediate error, no slave sees it
      do_txn(32'h7000_0000, 32'hDEAD_BEEF, 4'b1111, 4'b0000, 32'hBADC0DE5, 1'b1, 1, 0);

      // Slave 3 never answers: watchdog fires after 8 valid cycles
      lat[3] = NEVER;
      do_txn(32'hC300_0100, 32'h0, 4'b0000, 4'b1000, 32'hBADC0DE5, 1'b1, 9, 8);

      // Slave 3 answers on the last allowed cycle: ready wins over timeout
      lat[3] = 7; srd[3] = 32'h0F0F_1234;
      do_txn(32'hC300_0200, 32'h0, 4'b0000, 4'b1000, 32'h0F0F_1234, 1'b0, 9, 8);

`ifdef PICOMEM_MUX_ERRLOG_EN
      @(negedge clk);
      chk("log_valid", 32'(err_valid), 32'd1);
      chk("log_addr", err_addr, 32'h7000_0000);
      chk("log_timeout", 32'(err_timeout), 32'd0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("log_clr_valid", 32'(err_valid), 32'd0);
      chk("log_clr_addr", err_addr, 32'd0);
      chk("log_clr_timeout", 32'(err_timeout), 32'd0);
`endif

      // Asynchronous reset while a slave access is in flight
      lat[3] = NEVER;
      @(negedge clk);
      exp_sv = 4'b1000; exp_addr = 32'hC300_0000;
      exp_wdata = 32'h0; exp_wstrb = 4'b0000;
      picom_addr = 32'hC300_0000; picom_wdata = '0; picom_wstrb = '0;
      picom_valid = 1'b1;
      @(negedge clk);
      chk("pre_rst_valid", 32'(picos_valid), 32'b1000);
      @(negedge clk);
      resetn = 1'b0;
      picom_valid = 1'b0;
      #1;
      chk("async_rst_valid", 32'(picos_valid), 32'd0);
      chk("async_rst_ready", 32'(picom_ready), 32'd0);
      chk("async_rst_addr", picos_addr, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Normal transaction after reset release
      lat[0] = 2; srd[0] = 32'h1111_2222;
      do_txn(32'hC000_0020, 32'h0, 4'b0000, 4'b0001, 32'h1111_2222, 1'b0, 4, 3);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/picomem_mux_1_n.md
Name: picomem_mux_1_n

Overview:
- Parametrised, registered successor to the fixed 1-to-4 PicoMem address-decode mux.
- Routes one PicoRV32-style native memory master to NUM_SLAVES slaves.
- Uses per-slave base/mask decode and registered request/response stages.
- Adds an unmapped-address error responder and a per-transaction slave timeout watchdog.
- Sits between the CPU (or an upstream mux) and the peripheral/memory slaves, replacing cascaded 1-to-4 muxes.

Parameters:
- NUM_SLAVES, 4: number of slave ports, 1..16.
- ADDR_BASES, {32'hC300_0000,32'hC200_0000,32'hC100_0000,32'hC000_0000}: flattened NUM_SLAVES*32; slice i is the base of slave i.
- ADDR_MASKS, {4{32'hFF00_0000}}: flattened NUM_SLAVES*32; slice i is the compare mask of slave i.
- TIMEOUT_CYCLES, 1024: maximum cycles with slave valid high before forced error completion; 0 disables the watchdog. Range 0..65535.
- ERR_RDATA, 32'hBADC0DE5: read data returned on an unmapped or timed-out access.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- picom_valid  in  1  master request valid.
- picom_ready  out  1  master completion, one-cycle pulse.
- picom_addr  in  32  master address.
- picom_wdata  in  32  master write data.
- picom_wstrb  in  4  byte strobes; 0 = read.
- picom_rdata  out  32  read data, valid while picom_ready=1.
- picos_valid  out  NUM_SLAVES  one-hot slave request valid.
- picos_ready  in  NUM_SLAVES  slave completion, bit i from slave i.
- picos_addr  out  32  registered address, shared by all slaves.
- picos_wdata  out  32  registered write data, shared.
- picos_wstrb  out  4  registered strobes, shared.
- picos_rdata  in  NUM_SLAVES*32  slave read data; slice i from slave i.
- err_pulse  out  1  one-cycle pulse on any error completion.

Behaviour:
- Reset (asynchronous, resetn=0):
  - Outputs: picom_ready=0, picom_rdata=0, picos_valid=0, picos_addr/wdata/wstrb=0, err_pulse=0.
  - Internal: FSM=IDLE, timeout counter=0, latched select=0.
- Decode:
  - Slave i matches when (picom_addr & MASK_i) == (BASE_i & MASK_i).
  - If several slaves match, the lowest index wins.
  - No match means unmapped.
- FSM states: IDLE, ACTIVE, RESP.
  - IDLE, picom_valid=1 and mapped:
    - Latch addr/wdata/wstrb into picos_*.
    - Set picos_valid[sel]=1; clear the counter; go to ACTIVE.
  - IDLE, picom_valid=1 and unmapped:
    - Load picom_rdata=ERR_RDATA, picom_ready=1, err_pulse=1; go to RESP.
    - No slave sees the access; writes are dropped.
  - ACTIVE, picos_ready[sel]=1:
    - Capture picom_rdata=picos_rdata slice sel.
    - picom_ready=1; picos_valid=0; go to RESP.
    - The ready bits of unselected slaves are ignored.
  - ACTIVE, no ready: increment the counter.
  - ACTIVE, TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no ready:
    - Force picom_rdata=ERR_RDATA, picom_ready=1, err_pulse=1; picos_valid=0; go to RESP.
  - ACTIVE, slave ready in the same cycle as the timeout limit: slave ready wins, no error.
  - RESP: picom_ready and err_pulse drop to 0; go to IDLE unconditionally. picom_valid is not sampled in RESP.
- Latency:
  - Master valid seen in cycle 0 puts picos_valid in cycle 1.
  - Slave ready in cycle k (k>=1) gives picom_ready in cycle k+1.
  - Minimum round trip is 2 cycles with a zero-wait slave; unmapped access is 1 cycle.
- Handshake rules:
  - picom_* inputs are sampled only in IDLE.
  - picos_* outputs are stable from accept until ready or timeout.
  - picos_valid is never asserted on two slaves at once.
- A late slave ready arriving after a timeout (slave valid already low) is ignored.
- picom_rdata holds its last value outside picom_ready.

Optional Feature:
- Macro: PICOMEM_MUX_ERRLOG_EN.
- Defined: adds ports:
  - err_clr  in  1: synchronous clear of the log; wins over a same-cycle capture.
  - err_valid  out  1: sticky, set on first error.
  - err_addr  out  32: address of the first error since clear.
  - err_timeout  out  1: cause of the first error; 1 = timeout, 0 = unmapped.
  - Later errors do not overwrite the log until err_clr. All log outputs reset to 0.
- Undefined: these ports and registers are absent; err_pulse is unaffected.

Test Plan:
1. Zero-wait slave 2 (ready tied 1, rdata 32'h1234_5678), read 32'hC200_0010 -> picos_valid=4'b0100 in cycle 1; picom_ready with rdata 32'h1234_5678 in cycle 2.
2. Write 32'hC100_0004, wdata 32'hA5A5_0001, wstrb 4'b0011; slave 1 ready after 5 cycles -> picos_addr/wdata/wstrb stable throughout; picom_ready exactly once; picos_valid low the cycle after slave ready.
3. Access 32'h7000_0000 (unmapped) -> picom_ready plus err_pulse in cycle 1 with rdata 32'hBADC0DE5; all picos_valid stay 0.
4. TIMEOUT_CYCLES=8, slave 3 never ready -> picos_valid[3] high 8 cycles; then picom_ready, rdata 32'hBADC0DE5, err_pulse. Slave ready on cycle 8 instead -> normal data, no err_pulse.
5. resetn low while in ACTIVE -> picos_valid and picom_ready 0 immediately; next transaction after release completes normally.
6. With PICOMEM_MUX_ERRLOG_EN, unmapped then timeout error -> err_valid=1, err_addr = first address, err_timeout=0; after err_clr all three read 0.
